viterbi_frame_ctrl: RTL and testbench
=====================================

// Module: viterbi_frame_ctrl
// PURPOSE
//  Frame-level sequencer in front of the Viterbi decoder datapath (BMU/ACSU/SPMU).
//  Per frame: clears the decoder, gates the 2-bit symbol stream in with valid/ready,
//  injects flush symbols, and re-times decisions into a framed bit stream with last.
//  Sits between the symbol source and the decoder top; owns all decoder sequencing.
// PARAMETERS
//  LEN_W        12  width of frame-length field (info bits per frame, 1..2^LEN_W-1)
//  TAIL_LEN     2   encoder termination symbols per frame (K-1), carried in input stream
//  DELAY_SYM    4   decoder decision delay in valid symbols; = number of flush symbols
//  DRAIN_TO     64  watchdog: max cycles in DRAIN with no decision before abort
// PORTS
//  i_clk        in   1      clock
//  i_rst_n      in   1      synchronous active-low reset
//  i_start      in   1      start frame (sampled in IDLE only)
//  i_frame_len  in   LEN_W  info bits N for the frame, latched on accepted i_start
//  i_abort      in   1      abandon current frame
//  i_sym_valid  in   1      input symbol valid
//  i_sym_data   in   2      input code symbol
//  o_sym_ready  out  1      controller accepts symbol
//  o_dec_clear  out  1      1-cycle pulse: reset decoder path metrics / survivors
//  o_dec_valid  out  1      symbol valid to decoder (i_valid)
//  o_dec_data   out  2      symbol to decoder (i_data)
//  i_dec_valid  in   1      decoder o_valid
//  i_dec_bit    in   1      decoder o_decision
//  o_bit_valid  out  1      decoded info bit valid
//  o_bit_data   out  1      decoded info bit
//  o_bit_last   out  1      with o_bit_valid on bit N-1
//  o_busy       out  1      state != IDLE
//  o_err        out  1      1-cycle pulse: zero-length start or drain timeout
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state IDLE, all counters 0, every output 0.
//  FSM IDLE->CLEAR->RUN->FLUSH->DRAIN->IDLE.
//   IDLE : i_start & i_frame_len!=0 -> latch N, go CLEAR. i_start & N==0 -> o_err, stay.
//   CLEAR: o_dec_clear=1 for exactly 1 cycle; counters cleared; -> RUN.
//   RUN  : o_sym_ready=1 (combinational from state). Accept = i_sym_valid & o_sym_ready.
//          Accepted symbol registered to o_dec_data/o_dec_valid (1-cycle latency).
//          After N+TAIL_LEN accepts -> FLUSH (ready drops the cycle after last accept).
//   FLUSH: drive o_dec_valid=1, o_dec_data=2'b00 for DELAY_SYM consecutive cycles -> DRAIN.
//          DELAY_SYM=0 skips FLUSH.
//   DRAIN: wait until decision count = N+TAIL_LEN+DELAY_SYM -> IDLE; o_busy drops same edge.
//  Decision counter dcnt increments on every i_dec_valid in RUN/FLUSH/DRAIN.
//   dcnt < DELAY_SYM: discard. DELAY_SYM <= dcnt < DELAY_SYM+N: o_bit_valid=1,
//   o_bit_data=i_dec_bit, registered (1-cycle). o_bit_last on dcnt==DELAY_SYM+N-1.
//   Remaining TAIL_LEN decisions discarded. i_dec_valid in IDLE/CLEAR ignored.
//  Watchdog: counter resets on each i_dec_valid in DRAIN; reaching DRAIN_TO -> o_err,
//   IDLE, no o_bit_last issued if not yet sent.
//  i_abort (any non-IDLE state): next state IDLE, o_dec_clear pulsed once, no further
//   o_bit_valid; abort has priority over all same-cycle transitions. i_abort in IDLE: no-op.
//  i_start outside IDLE ignored (no error). i_frame_len changes mid-frame have no effect.
//  Counters LEN_W+3 bits wide; no wrap for legal N. Reset mid-frame: as power-on.
// STRUCTURE
//  Package viterbi_pkg: state enum typedef (IDLE,CLEAR,RUN,FLUSH,DRAIN), symbol typedef
//   logic[1:0], FLUSH_SYM=2'b00 constant.
//  One sub-module: viterbi_bit_framer (dcnt, discard window, bit/last registers).
// TESTING
//  1 N=8, symbols every cycle, ideal decoder model (delay DELAY_SYM) -> 8 o_bit_valid,
//    data matches encoder input, o_bit_last on 8th, ready high 10 accepts, 4 flush cycles.
//  2 N=8, i_sym_valid 50% random gaps -> same 8 bits; o_dec_valid only on accepts/flush.
//  3 i_start with N=0 -> o_err 1 cycle, o_busy stays 0, no o_dec_clear.
//  4 i_abort in RUN after 3 accepts -> IDLE next cycle, one o_dec_clear, no o_bit_*.
//  5 Decoder stalls in DRAIN (no i_dec_valid) -> o_err after 64 cycles, o_busy 0.
//  6 i_rst_n low mid-FLUSH -> all outputs 0 next cycle; new frame N=1 then decodes 1 bit.

Source files
------------

// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types for the Viterbi frame sequencer: FSM states, code symbol, flush symbol.
// Types only, so there is no latency and no backpressure.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4
    } state_e;

    typedef logic [1:0] sym_t;

    localparam sym_t FLUSH_SYM = 2'b00;

    // States in which decoder decisions belong to the current frame
    function automatic logic is_active(input state_e s);
        return (s == RUN) || (s == FLUSH) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol-in / decoder / bit-out bundle of the frame sequencer. The slave side is the controller.
// Wires only: no latency; backpressure is carried by o_sym_ready.
interface viterbi_frame_ctrl_if #(
    parameter int LEN_W = 12
);
    import viterbi_pkg::*;

    logic             i_start;
    logic [LEN_W-1:0] i_frame_len;
    logic             i_abort;
    logic             i_sym_valid;
    sym_t             i_sym_data;
    logic             o_sym_ready;
    logic             o_dec_clear;
    logic             o_dec_valid;
    sym_t             o_dec_data;
    logic             i_dec_valid;
    logic             i_dec_bit;
    logic             o_bit_valid;
    logic             o_bit_data;
    logic             o_bit_last;
    logic             o_busy;
    logic             o_err;

    modport slave (
        input  i_start, i_frame_len, i_abort, i_sym_valid, i_sym_data, i_dec_valid, i_dec_bit,
        output o_sym_ready, o_dec_clear, o_dec_valid, o_dec_data,
               o_bit_valid, o_bit_data, o_bit_last, o_busy, o_err
    );

    modport master (
        output i_start, i_frame_len, i_abort, i_sym_valid, i_sym_data, i_dec_valid, i_dec_bit,
        input  o_sym_ready, o_dec_clear, o_dec_valid, o_dec_data,
               o_bit_valid, o_bit_data, o_bit_last, o_busy, o_err
    );

endinterface

// File: rtl/viterbi_frame_ctrl_framer.sv
// Counts decoder decisions, drops the warm-up and tail window, and registers info bits with last.
// Latency 1 cycle from i_dec_valid to o_bit_valid; no backpressure, every decision is consumed.
module viterbi_bit_framer #(
    parameter int LEN_W     = 12,
    parameter int DELAY_SYM = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [LEN_W+2:0] i_n,
    input  logic             i_dec_valid,
    input  logic             i_dec_bit,
    output logic [LEN_W+2:0] o_dcnt,
    output logic             o_bit_valid,
    output logic             o_bit_data,
    output logic             o_bit_last
);
    localparam int CW = LEN_W + 3;

    logic [CW-1:0] dcnt_q, dcnt_d, win_lo, win_hi;
    logic          in_win, at_last;
    logic          bit_valid_q, bit_data_q, bit_last_q;

    assign win_lo  = CW'(DELAY_SYM);
    assign win_hi  = win_lo + i_n;
    assign dcnt_d  = dcnt_q + 1'b1;
    assign in_win  = (dcnt_q >= win_lo) && (dcnt_q < win_hi);
    assign at_last = (dcnt_q == win_hi - 1'b1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dcnt_q      <= '0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            bit_last_q  <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            bit_last_q  <= 1'b0;
            if (i_clr) begin
                dcnt_q <= '0;
            end else if (i_en && i_dec_valid) begin
                dcnt_q <= dcnt_d;
                if (in_win) begin
                    bit_valid_q <= 1'b1;
                    bit_data_q  <= i_dec_bit;
                    bit_last_q  <= at_last;
                end
            end
        end
    end

    assign o_dcnt      = dcnt_q;
    assign o_bit_valid = bit_valid_q;
    assign o_bit_data  = bit_data_q;
    assign o_bit_last  = bit_last_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Per-frame sequencer for the Viterbi decoder: clear, symbol gating, flush injection, bit framing.
// Symbols reach the decoder 1 cycle after accept; o_sym_ready is high only in RUN (bits 1 cycle after decision).
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int LEN_W     = 12,
    parameter int TAIL_LEN  = 2,
    parameter int DELAY_SYM = 4,
    parameter int DRAIN_TO  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    viterbi_frame_ctrl_if.slave  bus
);
    localparam int CW   = LEN_W + 3;
    localparam int WD_W = $clog2(DRAIN_TO + 1);

    state_e          state_q;
    logic [CW-1:0]   n_q, acnt_q, acnt_d, fcnt_q, fcnt_d, dcnt;
    logic [CW-1:0]   sym_total, dec_total;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            dec_clear_q, dec_valid_q, err_q;
    sym_t            dec_data_q;
    logic            framer_en;

    assign sym_total = n_q + CW'(TAIL_LEN);
    assign dec_total = sym_total + CW'(DELAY_SYM);
    assign acnt_d    = acnt_q + 1'b1;
    assign fcnt_d    = fcnt_q + 1'b1;
    assign wdog_d    = wdog_q + 1'b1;

    // Abort wins over every other transition, including the FSM's own exits
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            acnt_q      <= '0;
            fcnt_q      <= '0;
            wdog_q      <= '0;
            dec_clear_q <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_data_q  <= FLUSH_SYM;
            err_q       <= 1'b0;
        end else begin
            dec_clear_q <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_data_q  <= FLUSH_SYM;
            err_q       <= 1'b0;
            if (state_q != IDLE && bus.i_abort) begin
                state_q     <= IDLE;
                dec_clear_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.i_start) begin
                            if (bus.i_frame_len != '0) begin
                                n_q         <= CW'(bus.i_frame_len);
                                dec_clear_q <= 1'b1;
                                state_q     <= CLEAR;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        acnt_q  <= '0;
                        fcnt_q  <= '0;
                        wdog_q  <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (bus.i_sym_valid) begin
                            dec_valid_q <= 1'b1;
                            dec_data_q  <= bus.i_sym_data;
                            acnt_q      <= acnt_d;
                            if (acnt_d == sym_total)
                                state_q <= (DELAY_SYM == 0) ? DRAIN : FLUSH;
                        end
                    end
                    FLUSH: begin
                        dec_valid_q <= 1'b1;
                        fcnt_q      <= fcnt_d;
                        if (fcnt_d == CW'(DELAY_SYM))
                            state_q <= DRAIN;
                    end
                    DRAIN: begin
                        if (dcnt == dec_total) begin
                            state_q <= IDLE;
                        end else if (bus.i_dec_valid) begin
                            wdog_q <= '0;
                        end else begin
                            wdog_q <= wdog_d;
                            if (wdog_d == WD_W'(DRAIN_TO)) begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign framer_en = is_active(state_q) && !bus.i_abort;

    logic bit_valid, bit_data, bit_last;

    viterbi_bit_framer #(
        .LEN_W     (LEN_W),
        .DELAY_SYM (DELAY_SYM)
    ) u_framer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (state_q == CLEAR),
        .i_en        (framer_en),
        .i_n         (n_q),
        .i_dec_valid (bus.i_dec_valid),
        .i_dec_bit   (bus.i_dec_bit),
        .o_dcnt      (dcnt),
        .o_bit_valid (bit_valid),
        .o_bit_data  (bit_data),
        .o_bit_last  (bit_last)
    );

    assign bus.o_sym_ready = (state_q == RUN);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_dec_clear = dec_clear_q;
    assign bus.o_dec_valid = dec_valid_q;
    assign bus.o_dec_data  = dec_data_q;
    assign bus.o_err       = err_q;
    assign bus.o_bit_valid = bit_valid;
    assign bus.o_bit_data  = bit_data;
    assign bus.o_bit_last  = bit_last;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a K=3 encoder and an ideal fixed-delay decoder model.
module tb_viterbi_frame_ctrl;

    localparam int DELAY = 4;
    localparam int TAIL  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.LEN_W(12)) bus ();

    viterbi_frame_ctrl #(
        .LEN_W(12), .TAIL_LEN(TAIL), .DELAY_SYM(DELAY), .DRAIN_TO(64)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int acc_cnt, dv_cnt, clr_cnt, err_cnt, busy_cnt, rx_cnt, last_cnt, last_pos, err_cyc, last_dv_cyc;
    logic       rx_bits [64];
    logic [1:0] dv_dat  [128];
    logic       tx_bits [64];
    logic [1:0] tx_syms [80];
    int n_cur = 0;
    int dec_j = 0;
    bit dec_en = 1'b1;

    // Monitor: everything sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.o_bit_valid) begin
            if (rx_cnt < 64) rx_bits[rx_cnt] = bus.o_bit_data;
            if (bus.o_bit_last) begin last_cnt++; last_pos = rx_cnt; end
            rx_cnt++;
        end else if (bus.o_bit_last) begin
            last_cnt++;
        end
        if (bus.o_dec_valid) begin
            if (dv_cnt < 128) dv_dat[dv_cnt] = bus.o_dec_data;
            dv_cnt++;
            last_dv_cyc = cyc;
        end
        if (bus.o_dec_clear) clr_cnt++;
        if (bus.o_err) begin err_cnt++; err_cyc = cyc; end
        if (bus.o_busy) busy_cnt++;
        if (bus.i_sym_valid && bus.o_sym_ready) acc_cnt++;
    end

    // Ideal decoder: one decision per symbol, decision j carries info bit j-DELAY, else filler 1
    initial begin
        bus.i_dec_valid = 1'b0;
        bus.i_dec_bit   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dec_en && bus.o_dec_valid) begin
                bus.i_dec_valid = 1'b1;
                if (dec_j >= DELAY && dec_j < DELAY + n_cur) bus.i_dec_bit = tx_bits[dec_j - DELAY];
                else bus.i_dec_bit = 1'b1;
                dec_j++;
            end else begin
                bus.i_dec_valid = 1'b0;
                bus.i_dec_bit   = 1'b0;
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clr_mon;
        acc_cnt = 0; dv_cnt = 0; clr_cnt = 0; err_cnt = 0; busy_cnt = 0;
        rx_cnt = 0; last_cnt = 0; last_pos = -1; err_cyc = 0; last_dv_cyc = 0;
        dec_j = 0;
    endtask

    // Rate-1/2 K=3 (7,5) encoder with TAIL zero termination bits
    task automatic make_frame(input int n, input logic [31:0] pattern);
        logic s1, s0, b;
        s1 = 1'b0; s0 = 1'b0;
        n_cur = n;
        for (int i = 0; i < n + TAIL; i++) begin
            b = (i < n) ? pattern[i] : 1'b0;
            if (i < n) tx_bits[i] = b;
            tx_syms[i] = {b ^ s1 ^ s0, b ^ s0};
            s0 = s1; s1 = b;
        end
    endtask

    task automatic start_frame(input int n);
        step;
        bus.i_start = 1'b1; bus.i_frame_len = 12'(n);
        step;
        bus.i_start = 1'b0; bus.i_frame_len = 12'd3;
    endtask

    // Returns just after the edge that takes the last requested symbol
    task automatic drive_syms(input int cnt, input bit gaps);
        int k, guard;
        k = 0; guard = 0;
        while (k < cnt && guard < 1000) begin
            step;
            if (gaps && $urandom_range(1) == 0) begin
                bus.i_sym_valid = 1'b0;
            end else begin
                bus.i_sym_valid = 1'b1;
                bus.i_sym_data  = tx_syms[k];
            end
            @(negedge clk);
            if (bus.i_sym_valid && bus.o_sym_ready) k++;
            guard++;
        end
        step;
        bus.i_sym_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.o_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        bus.i_start = 0; bus.i_frame_len = 0; bus.i_abort = 0;
        bus.i_sym_valid = 0; bus.i_sym_data = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_sym_ready, bus.o_dec_clear, bus.o_dec_valid, bus.o_dec_data,
             bus.o_bit_valid, bus.o_bit_data, bus.o_bit_last, bus.o_err} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {bus.o_busy, bus.o_sym_ready, bus.o_dec_clear,
                     bus.o_dec_valid, bus.o_dec_data, bus.o_bit_valid, bus.o_bit_data, bus.o_bit_last, bus.o_err});
        end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_basic;
        bit ok;
        logic [1:0] exp;
        make_frame(8, 32'hB4);
        clr_mon; dec_en = 1'b1;
        start_frame(8);
        drive_syms(10, 1'b0);
        // Keep offering symbols: none may be taken once the frame's 10 are in
        bus.i_sym_valid = 1'b1; bus.i_sym_data = 2'b11;
        wait_idle(200, ok);
        step; bus.i_sym_valid = 1'b0;
        repeat (2) step;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_done: busy still high after 200 cycles"); end
        n_cmp++; if (acc_cnt !== 10) begin n_bad++; $display("FAIL basic_accepts: got %0d want 10", acc_cnt); end
        n_cmp++; if (dv_cnt !== 14) begin n_bad++; $display("FAIL basic_dec_valid: got %0d want 14", dv_cnt); end
        for (int i = 0; i < 14; i++) begin
            exp = (i < 10) ? tx_syms[i] : 2'b00;
            n_cmp++;
            if (dv_dat[i] !== exp) begin n_bad++; $display("FAIL basic_dec_data[%0d]: got %b want %b", i, dv_dat[i], exp); end
        end
        n_cmp++; if (rx_cnt !== 8) begin n_bad++; $display("FAIL basic_bit_count: got %0d want 8", rx_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rx_bits[i] !== tx_bits[i]) begin n_bad++; $display("FAIL basic_bit[%0d]: got %b want %b", i, rx_bits[i], tx_bits[i]); end
        end
        n_cmp++; if (last_cnt !== 1) begin n_bad++; $display("FAIL basic_last_count: got %0d want 1", last_cnt); end
        n_cmp++; if (last_pos !== 7) begin n_bad++; $display("FAIL basic_last_pos: got %0d want 7", last_pos); end
        n_cmp++; if (clr_cnt !== 1) begin n_bad++; $display("FAIL basic_clear: got %0d want 1", clr_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_gaps;
        bit ok;
        logic [1:0] exp;
        make_frame(8, 32'h6D);
        clr_mon; dec_en = 1'b1;
        start_frame(8);
        drive_syms(10, 1'b1);
        wait_idle(300, ok);
        repeat (2) step;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL gaps_done: busy still high after 300 cycles"); end
        n_cmp++; if (dv_cnt !== 14) begin n_bad++; $display("FAIL gaps_dec_valid: got %0d want 14", dv_cnt); end
        for (int i = 0; i < 14; i++) begin
            exp = (i < 10) ? tx_syms[i] : 2'b00;
            n_cmp++;
            if (dv_dat[i] !== exp) begin n_bad++; $display("FAIL gaps_dec_data[%0d]: got %b want %b", i, dv_dat[i], exp); end
        end
        n_cmp++; if (rx_cnt !== 8) begin n_bad++; $display("FAIL gaps_bit_count: got %0d want 8", rx_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rx_bits[i] !== tx_bits[i]) begin n_bad++; $display("FAIL gaps_bit[%0d]: got %b want %b", i, rx_bits[i], tx_bits[i]); end
        end
        n_cmp++; if (last_pos !== 7) begin n_bad++; $display("FAIL gaps_last_pos: got %0d want 7", last_pos); end
    endtask

    task automatic test_zero_len;
        clr_mon;
        start_frame(0);
        repeat (4) step;
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL zero_err: got %0d want 1", err_cnt); end
        n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", busy_cnt); end
        n_cmp++; if (clr_cnt !== 0) begin n_bad++; $display("FAIL zero_clear: got %0d want 0", clr_cnt); end
        // Abort while idle does nothing
        bus.i_abort = 1'b1; step; bus.i_abort = 1'b0;
        repeat (3) step;
        n_cmp++; if (clr_cnt !== 0) begin n_bad++; $display("FAIL idle_abort_clear: got %0d want 0", clr_cnt); end
    endtask

    task automatic test_abort;
        make_frame(8, 32'h5A);
        clr_mon; dec_en = 1'b1;
        start_frame(8);
        drive_syms(3, 1'b0);
        bus.i_abort = 1'b1;
        step;
        bus.i_abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.o_busy); end
        n_cmp++; if (bus.o_dec_clear !== 1'b1) begin n_bad++; $display("FAIL abort_clear_pulse: got %b want 1", bus.o_dec_clear); end
        repeat (20) step;
        n_cmp++; if (clr_cnt !== 2) begin n_bad++; $display("FAIL abort_clear_count: got %0d want 2", clr_cnt); end
        n_cmp++; if (acc_cnt !== 3) begin n_bad++; $display("FAIL abort_accepts: got %0d want 3", acc_cnt); end
        n_cmp++; if (dv_cnt !== 3) begin n_bad++; $display("FAIL abort_dec_valid: got %0d want 3", dv_cnt); end
        n_cmp++; if (rx_cnt !== 0 || last_cnt !== 0) begin n_bad++; $display("FAIL abort_bits: got %0d bits %0d last want 0 0", rx_cnt, last_cnt); end
    endtask

    task automatic test_drain_timeout;
        bit ok;
        make_frame(2, 32'h1);
        clr_mon; dec_en = 1'b0;
        start_frame(2);
        drive_syms(4, 1'b0);
        wait_idle(300, ok);
        repeat (2) step;
        dec_en = 1'b1;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_idle: busy still high after 300 cycles"); end
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt); end
        n_cmp++; if (err_cyc - last_dv_cyc !== 64) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 64", err_cyc - last_dv_cyc); end
        n_cmp++; if (dv_cnt !== 8) begin n_bad++; $display("FAIL timeout_dec_valid: got %0d want 8", dv_cnt); end
        n_cmp++; if (rx_cnt !== 0 || last_cnt !== 0) begin n_bad++; $display("FAIL timeout_bits: got %0d bits %0d last want 0 0", rx_cnt, last_cnt); end
    endtask

    task automatic test_reset_mid_flush;
        bit ok;
        make_frame(4, 32'h9);
        clr_mon; dec_en = 1'b1;
        start_frame(4);
        drive_syms(6, 1'b0);
        step;
        rst_n = 1'b0;
        step;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_sym_ready, bus.o_dec_clear, bus.o_dec_valid, bus.o_dec_data,
             bus.o_bit_valid, bus.o_bit_data, bus.o_bit_last, bus.o_err} !== 10'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b want 0", {bus.o_busy, bus.o_sym_ready, bus.o_dec_clear,
                     bus.o_dec_valid, bus.o_dec_data, bus.o_bit_valid, bus.o_bit_data, bus.o_bit_last, bus.o_err});
        end
        step;
        rst_n = 1'b1;
        make_frame(1, 32'h1);
        clr_mon;
        start_frame(1);
        drive_syms(3, 1'b0);
        wait_idle(200, ok);
        repeat (2) step;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL n1_done: busy still high after 200 cycles"); end
        n_cmp++; if (rx_cnt !== 1) begin n_bad++; $display("FAIL n1_bit_count: got %0d want 1", rx_cnt); end
        n_cmp++; if (rx_bits[0] !== 1'b1) begin n_bad++; $display("FAIL n1_bit: got %b want 1", rx_bits[0]); end
        n_cmp++; if (last_cnt !== 1 || last_pos !== 0) begin n_bad++; $display("FAIL n1_last: got %0d at %0d want 1 at 0", last_cnt, last_pos); end
        n_cmp++; if (dv_cnt !== 7) begin n_bad++; $display("FAIL n1_dec_valid: got %0d want 7", dv_cnt); end
    endtask

    initial begin
        clr_mon;
        test_reset;
        test_basic;
        test_gaps;
        test_zero_len;
        test_abort;
        test_drain_timeout;
        test_reset_mid_flush;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles want fewer", cyc);
        $fatal(1);
    end

endmodule
